// File: rtl/sync_mod_counter.sv
// sync_mod_counter: edge-triggered up/down modulo counter with load, terminal-count pulse and
// optional seven-segment output (define SYNC_MOD_COUNTER_SEG_EN to enable the decoder).
module sync_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [6:0]       leds
);
    localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    logic             step_d, step_edge, at_top, at_bot, hit;
    logic [WIDTH-1:0] next_count, load_clamped;
    always_comb begin
        step_edge    = step & ~step_d;
        at_top       = count == TOP;
        at_bot       = count == '0;
        hit          = up ? at_top : at_bot;
        next_count   = up ? (at_top ? (SATURATE ? count : '0) : count + 1'b1)
                          : (at_bot ? (SATURATE ? count : TOP) : count - 1'b1);
        load_clamped = ({1'b0, load_value} >= MOD) ? TOP : load_value;
    end
    // step_d resets high so a step already held at reset release is not counted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_d <= 1'b1;
            count  <= '0;
            tc     <= 1'b0;
        end else begin
            step_d <= step;
            count  <= load ? load_clamped : step_edge ? next_count : count;
            tc     <= !load && step_edge && hit;
        end
    end
`ifdef SYNC_MOD_COUNTER_SEG_EN
    logic [3:0] nib;
    always_comb begin
        nib = 4'(count);
        case (nib)
            4'h0: leds = 7'b1000000;
            4'h1: leds = 7'b1111001;
            4'h2: leds = 7'b0100100;
            4'h3: leds = 7'b0110000;
            4'h4: leds = 7'b0011001;
            4'h5: leds = 7'b0010010;
            4'h6: leds = 7'b0000010;
            4'h7: leds = 7'b1111000;
            4'h8: leds = 7'b0000000;
            4'h9: leds = 7'b0010000;
            4'hA: leds = 7'b0001000;
            4'hB: leds = 7'b0000011;
            4'hC: leds = 7'b1000110;
            4'hD: leds = 7'b0100001;
            4'hE: leds = 7'b0000110;
            default: leds = 7'b0001110;
        endcase
    end
`else
    assign leds = 7'b1111111;
`endif
endmodule

// File: tb/tb_sync_mod_counter.sv
// tb_sync_mod_counter: directed checks of wrapping and saturating counters driven in parallel.
module tb_sync_mod_counter;
    logic       clk = 1'b0, reset = 1'b0, step = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s;
    logic [6:0] leds_w, leds_s;
    int         n_checks = 0, n_errors = 0;
`ifdef SYNC_MOD_COUNTER_SEG_EN
    localparam logic [6:0] LED0 = 7'b1000000;
    localparam logic [6:0] LED3 = 7'b0110000;
`else
    localparam logic [6:0] LED0 = 7'b1111111;
    localparam logic [6:0] LED3 = 7'b1111111;
`endif
    always #5 clk = ~clk;
    sync_mod_counter u_wrap (
        .clk(clk), .reset(reset), .step(step), .up(up), .load(load),
        .load_value(load_value), .count(count_w), .tc(tc_w), .leds(leds_w)
    );
    sync_mod_counter #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .step(step), .up(up), .load(load),
        .load_value(load_value), .count(count_s), .tc(tc_s), .leds(leds_s)
    );
    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic pulse(input logic dir, input int ew, input int tw, input int es, input int ts);
        @(negedge clk) begin step = 1'b1; up = dir; end
        @(negedge clk) step = 1'b0;
        check("wrap count", count_w, ew);
        check("wrap tc", tc_w, tw);
        check("sat count", count_s, es);
        check("sat tc", tc_s, ts);
        @(negedge clk);
        check("wrap tc clear", tc_w, 0);
        check("sat tc clear", tc_s, 0);
    endtask
    task automatic load_val(input logic [3:0] v);
        @(negedge clk) begin load = 1'b1; load_value = v; end
        @(negedge clk) load = 1'b0;
    endtask
    task automatic check_both(input string tag, input int ew, input int es);
        check({tag, " wrap"}, count_w, ew);
        check({tag, " sat"}, count_s, es);
    endtask
    initial begin
        #1;
        check_both("reset count", 0, 0);
        check("reset tc", tc_w, 0);
        check("reset leds", leds_w, LED0);
        @(negedge clk) reset = 1'b1;
        for (int i = 1; i <= 12; i++)
            pulse(1'b1, i % 10, int'(i == 10), (i > 9) ? 9 : i, int'(i >= 10));
        load_val(4'd0);
        check_both("load zero", 0, 0);
        pulse(1'b0, 9, 1, 0, 1);
        load_val(4'd3);
        @(negedge clk) begin step = 1'b1; up = 1'b1; end
        repeat (20) @(negedge clk);
        check_both("held step", 4, 4);
        check("held tc", tc_w, 0);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk) begin step = 1'b1; load = 1'b1; load_value = 4'd7; end
        @(negedge clk) load = 1'b0;
        check_both("load over edge", 7, 7);
        check("load tc wrap", tc_w, 0);
        check("load tc sat", tc_s, 0);
        @(negedge clk);
        check_both("no replay", 7, 7);
        step = 1'b0;
        load_val(4'd14);
        check_both("load clamp", 9, 9);
        load_val(4'd3);
        check("leds wrap", leds_w, LED3);
        check("leds sat", leds_s, LED3);
        load_val(4'd5);
        pulse(1'b0, 4, 0, 4, 0);
        load_val(4'd5);
        check_both("pre reset", 5, 5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_both("async reset", 0, 0);
        check("async reset tc", tc_w, 0);
        #1 reset = 1'b1;
        load_val(4'd9);
        @(negedge clk) begin step = 1'b1; up = 1'b1; end
        @(posedge clk);
        #1 check("tc before reset", tc_w, 1);
        #1 reset = 1'b0;
        #1 check("async reset tc wrap", tc_w, 0);
        check("async reset tc sat", tc_s, 0);
        check_both("async reset 2", 0, 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        check_both("step across release", 0, 0);
        step = 1'b0;
        pulse(1'b1, 1, 0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
